// File: rtl/dkongjr_snd_mix.sv
// Sound output mixer: offset-binary DAC sample -> signed, one-pole IIR low-pass,
// discrete-effects mix and 16-bit saturation, one output sample per sample period.
module dkongjr_snd_mix #(
    parameter int SAMPLE_CNT  = 1114,
    parameter int FILT_SHIFT  = 2,
    parameter int DAC_GAIN_SH = 6,
    parameter int SFX_GAIN_SH = 1
) (
    input  logic        I_CLK,
    input  logic        I_RESET_n,
    input  logic [7:0]  I_DAC_DAT,
    input  logic [15:0] I_SFX_DAT,
    input  logic        I_SFX_VLD,
    input  logic        I_MUTE,
    output logic [15:0] O_SND,
    output logic        O_SND_VLD
);

    localparam int CW = $clog2(SAMPLE_CNT);

    typedef enum logic [1:0] {IDLE, FILT, MIX, SAT} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic signed [19:0] x;
    logic signed [19:0] acc;
    logic signed [19:0] sum;
    logic signed [15:0] s;
    logic signed [15:0] sfx_hold;

    logic signed [7:0]  dac_s;
    logic signed [19:0] dac_x;
    logic signed [15:0] sfx_sel;
    logic signed [19:0] diff;
    logic signed [19:0] filt_step;
    logic signed [19:0] s_ext;
    logic signed [19:0] s_scaled;

    // Offset binary to two's complement is just an MSB flip.
    assign dac_s     = {~I_DAC_DAT[7], I_DAC_DAT[6:0]};
    assign dac_x     = {{12{dac_s[7]}}, dac_s} <<< DAC_GAIN_SH;
    assign sfx_sel   = I_SFX_VLD ? I_SFX_DAT : sfx_hold;
    assign diff      = x - acc;
    assign filt_step = diff >>> FILT_SHIFT;
    assign s_ext     = {{4{s[15]}}, s};
    assign s_scaled  = s_ext >>> SFX_GAIN_SH;

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(SAMPLE_CNT - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            state     <= IDLE;
            x         <= '0;
            s         <= '0;
            acc       <= '0;
            sum       <= '0;
            sfx_hold  <= '0;
            O_SND     <= '0;
            O_SND_VLD <= 1'b0;
        end else begin
            O_SND_VLD <= 1'b0;
            if (I_SFX_VLD)
                sfx_hold <= I_SFX_DAT;
            case (state)
                IDLE: begin
                    if (tick) begin
                        x     <= I_MUTE ? '0 : dac_x;
                        s     <= I_MUTE ? '0 : sfx_sel;
                        state <= FILT;
                    end
                end
                FILT: begin
                    acc   <= acc + filt_step;
                    state <= MIX;
                end
                MIX: begin
                    sum   <= acc + s_scaled;
                    state <= SAT;
                end
                SAT: begin
                    if (sum > 20'sd32767)
                        O_SND <= 16'h7FFF;
                    else if (sum < -20'sd32768)
                        O_SND <= 16'h8000;
                    else
                        O_SND <= sum[15:0];
                    O_SND_VLD <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
